hold_pulse_tx: RTL and testbench

- Transmit side of the button hold-duration detector: drives a single line high for a programmed number of prescaled ticks, so the detector's AND/flop chains reach the selected level.
- Drops the line for a mandatory release gap after each press.
- Sits in the same TinyTapeout 8-in/8-out tile; clock and reset arrive on io_in bits, and the prescaler matches the detector's ripple-divider sample rate.
- Fully synchronous single-clock design; the prescaler is an enable, not a derived clock.

---
 rtl/hold_pulse_tx.sv | 155 +++++++++++++++
 tb/tb_hold_pulse_tx.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hold_pulse_tx.sv
// Transmit side of the button hold-duration detector: raises the tx line for a
// programmed number of prescaler ticks, then forces a release gap.
module hold_pulse_tx #(
    parameter int unsigned PRESCALE_BITS = 14,
    parameter int unsigned LVL0_TICKS    = 12,
    parameter int unsigned LVL1_TICKS    = 24,
    parameter int unsigned LVL2_TICKS    = 36,
    parameter int unsigned LVL3_TICKS    = 48,
    parameter int unsigned GAP_TICKS     = 4
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    if (PRESCALE_BITS < 1 ||
        LVL0_TICKS < 1 || LVL0_TICKS > 63 || LVL1_TICKS < 1 || LVL1_TICKS > 63 ||
        LVL2_TICKS < 1 || LVL2_TICKS > 63 || LVL3_TICKS < 1 || LVL3_TICKS > 63 ||
        GAP_TICKS < 1 || GAP_TICKS > 63) begin : g_bad_param
        $error("hold_pulse_tx: tick counts must be 1..63 and PRESCALE_BITS >= 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        HOLD = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam logic [5:0]               GAP_LOAD  = 6'(GAP_TICKS);
    localparam logic [PRESCALE_BITS-1:0] PRESC_ONE = PRESCALE_BITS'(1);

    logic clk;
    logic rst;
    logic unused_pins;

    assign clk         = io_in[0];
    assign rst         = io_in[7];
    assign unused_pins = &{1'b0, io_in[6:5]};

    state_t                   state, state_nxt;
    logic [5:0]               cnt, cnt_nxt;
    logic [1:0]               level, level_nxt;
    logic                     aborted, aborted_nxt;
    logic                     done, done_nxt;
    logic [PRESCALE_BITS-1:0] presc;
    logic                     tick;
    logic                     start_meta, start_sync, start_prev;
    logic                     abort_meta, abort_sync;
    logic                     start_edge;

    function automatic logic [5:0] level_ticks(input logic [1:0] code);
        case (code)
            2'd0:    return 6'(LVL0_TICKS);
            2'd1:    return 6'(LVL1_TICKS);
            2'd2:    return 6'(LVL2_TICKS);
            default: return 6'(LVL3_TICKS);
        endcase
    endfunction

    assign tick       = &presc;
    assign start_edge = start_sync & ~start_prev;

    // Two-flop synchronisers plus one history flop for start edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_meta <= 1'b0;
            start_sync <= 1'b0;
            start_prev <= 1'b0;
            abort_meta <= 1'b0;
            abort_sync <= 1'b0;
            presc      <= '0;
        end else begin
            start_meta <= io_in[1];
            start_sync <= start_meta;
            start_prev <= start_sync;
            abort_meta <= io_in[4];
            abort_sync <= abort_meta;
            presc      <= presc + PRESC_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 6'd0;
            level   <= 2'd0;
            aborted <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            level   <= level_nxt;
            aborted <= aborted_nxt;
            done    <= done_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        level_nxt   = level;
        aborted_nxt = aborted;
        done_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (start_edge) begin
                    state_nxt   = ARM;
                    level_nxt   = io_in[3:2];
                    cnt_nxt     = level_ticks(io_in[3:2]);
                    aborted_nxt = 1'b0;
                end
            end
            ARM: begin
                // Abort takes priority over the tick that would start the hold
                if (abort_sync) begin
                    state_nxt   = GAP;
                    cnt_nxt     = GAP_LOAD;
                    aborted_nxt = 1'b1;
                end else if (tick) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (abort_sync) begin
                    state_nxt   = GAP;
                    cnt_nxt     = GAP_LOAD;
                    aborted_nxt = 1'b1;
                end else if (tick) begin
                    if (cnt == 6'd1) begin
                        state_nxt = GAP;
                        cnt_nxt   = GAP_LOAD;
                    end else begin
                        cnt_nxt = cnt - 6'd1;
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    if (cnt == 6'd1) begin
                        state_nxt = IDLE;
                        cnt_nxt   = 6'd0;
                        done_nxt  = ~aborted;
                    end else begin
                        cnt_nxt = cnt - 6'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // tx and busy decode straight from the state register so reset drops them at once
    assign io_out = {state, level, tick, done, (state != IDLE), (state == HOLD)};

endmodule

// File: tb/tb_hold_pulse_tx.sv
// Bench for hold_pulse_tx: every clock is compared against a deadline-based
// reference model, plus table-driven press vectors and hand-written corner sequences.
module tb_hold_pulse_tx;

    localparam int PB = 2;
    localparam int P  = 4;   // clocks per tick
    localparam int G  = 4;   // gap ticks

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [1:0] level = 2'd0;
    logic [7:0] io_in;
    logic [7:0] io_out;

    assign io_in = {rst, 2'b00, abort, level, start, clk};

    hold_pulse_tx #(
        .PRESCALE_BITS(PB),
        .LVL0_TICKS   (12),
        .LVL1_TICKS   (24),
        .LVL2_TICKS   (36),
        .LVL3_TICKS   (48),
        .GAP_TICKS    (G)
    ) dut (
        .io_in (io_in),
        .io_out(io_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Reference model: pin history per clock edge and absolute-edge deadlines
    bit         sp[$];
    bit         ap[$];
    logic [1:0] lp[$];
    int         k;
    int         m_state;
    int         m_end;
    int         m_n;
    bit         m_aborted;
    bit         m_done;
    logic [1:0] m_level;

    typedef struct {
        logic [1:0] lv;
        int         abort_after;
        int         exp_tx;
        int         exp_done;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic bit sp_at(int e);
        return (e >= 1 && e <= sp.size()) ? sp[e-1] : 1'b0;
    endfunction

    function automatic bit ap_at(int e);
        return (e >= 1 && e <= ap.size()) ? ap[e-1] : 1'b0;
    endfunction

    task automatic model_reset();
        sp.delete();
        ap.delete();
        lp.delete();
        k         = 0;
        m_state   = 0;
        m_end     = 0;
        m_n       = 0;
        m_aborted = 1'b0;
        m_done    = 1'b0;
        m_level   = 2'd0;
    endtask

    task automatic model_abort();
        m_state   = 3;
        m_aborted = 1'b1;
        // the gap needs G ticks, counted from the first tick at or after this edge
        m_end     = k + (P - 1 - (k % P)) + P * (G - 1) + 1;
    endtask

    // Advance the model across clock edge k, using values present just before it
    task automatic model_step();
        bit tk;
        bit st_seen;
        bit ab;
        tk      = ((k - 1) % P) == (P - 1);
        st_seen = sp_at(k - 2) && !sp_at(k - 3);
        ab      = ap_at(k - 2);
        m_done  = 1'b0;
        case (m_state)
            0: if (st_seen) begin
                m_state   = 1;
                m_level   = lp[k-1];
                m_n       = 12 * (int'(m_level) + 1);
                m_aborted = 1'b0;
            end
            1: if (ab) model_abort();
               else if (tk) begin
                   m_state = 2;
                   m_end   = k + m_n * P;
               end
            2: if (ab) model_abort();
               else if (k == m_end) begin
                   m_state = 3;
                   m_end   = k + G * P;
               end
            default: if (k == m_end) begin
                m_state = 0;
                m_done  = !m_aborted;
            end
        endcase
    endtask

    task automatic cycle();
        logic [7:0] e;
        logic [1:0] ms;
        @(posedge clk);
        sp.push_back(start);
        ap.push_back(abort);
        lp.push_back(level);
        k++;
        model_step();
        #1;
        ms = 2'(m_state);
        e  = {ms, m_level, ((k % P) == (P - 1)), m_done, (m_state != 0), (m_state == 2)};
        checks++;
        if (io_out === e) passes++;
        else $display("FAIL cycle_out at edge %0d: got %02h, expected %02h", k, io_out, e);
    endtask

    task automatic press(input logic [1:0] lv, input int abort_after, input int retrig_at,
                         input int lvl_change_at, input bit hold_start,
                         output int txc, output int donec);
        int r;
        bit seen, ab_set, lc_set, finished;
        txc = 0; donec = 0; r = -1;
        seen = 0; ab_set = 0; lc_set = 0; finished = 0;
        level = lv;
        start = 1'b1;
        for (int n = 0; n < 800; n++) begin
            cycle();
            if (io_out[0]) txc++;
            if (io_out[2]) donec++;
            if (io_out[1]) seen = 1;
            else if (seen) begin
                finished = 1;
                break;
            end
            if (retrig_at >= 0 && r < 0 && txc == retrig_at) r = n;
            if (abort_after >= 0 && !ab_set && txc == abort_after) begin
                abort  = 1'b1;
                ab_set = 1;
            end
            if (lvl_change_at >= 0 && !lc_set && txc == lvl_change_at) begin
                level  = 2'd2;
                lc_set = 1;
            end
            start = hold_start || (n < 3) || (r >= 0 && n >= r + 2 && n < r + 6);
        end
        if (!finished) begin
            checks++;
            $display("FAIL press_timeout: got busy=%0d, expected a completed press", io_out[1]);
        end
        abort = 1'b0;
        start = hold_start;
    endtask

    initial begin
        int txc, dc, bc, len, a, et, ed;
        logic [1:0] lv;

        vecs[0] = '{2'd0, -1,  48, 1};
        vecs[1] = '{2'd1, -1,  96, 1};
        vecs[2] = '{2'd2, -1, 144, 1};
        vecs[3] = '{2'd3, -1, 192, 1};
        vecs[4] = '{2'd1, 20,  22, 0};
        vecs[5] = '{2'd3, 100, 102, 0};
        vecs[6] = '{2'd0, 46,  48, 0};   // abort lands on the natural end edge
        vecs[7] = '{2'd2, 143, 144, 1};  // abort arrives during the gap

        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        #1 check("reset_state", io_out, 8'h00);

        for (int i = 0; i < 8; i++) begin
            press(vecs[i].lv, vecs[i].abort_after, -1, -1, 1'b0, txc, dc);
            check("tbl_tx_len", txc, vecs[i].exp_tx);
            check("tbl_done", dc, vecs[i].exp_done);
            check("tbl_level_out", io_out[5:4], vecs[i].lv);
            check("tbl_state_idle", io_out[7:6], 0);
            repeat (3) cycle();
        end

        press(2'd1, -1, 10, -1, 1'b0, txc, dc);
        check("retrigger_tx_len", txc, 96);
        check("retrigger_done", dc, 1);
        repeat (3) cycle();

        press(2'd1, -1, -1, 10, 1'b0, txc, dc);
        check("level_change_tx_len", txc, 96);
        check("level_change_latched", io_out[5:4], 1);
        repeat (3) cycle();

        press(2'd0, -1, -1, -1, 1'b1, txc, dc);
        check("held_start_tx_len", txc, 48);
        bc = 0;
        repeat (30) begin
            cycle();
            if (io_out[1]) bc++;
        end
        check("held_start_no_retrigger", bc, 0);
        start = 1'b0;
        repeat (3) cycle();
        press(2'd0, -1, -1, -1, 1'b0, txc, dc);
        check("fresh_edge_tx_len", txc, 48);
        repeat (3) cycle();

        level = 2'd2;
        start = 1'b1;
        txc = 0;
        for (int n = 0; n < 100 && txc < 8; n++) begin
            cycle();
            if (io_out[0]) txc++;
            if (n == 3) start = 1'b0;
        end
        start = 1'b0;
        check("reset_press_in_hold", io_out[0], 1);
        #2 rst = 1'b1;
        #1 check("async_reset_out", io_out, 8'h00);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        bc = 0;
        repeat (20) begin
            cycle();
            if (io_out[1]) bc++;
        end
        check("after_reset_idle", bc, 0);
        press(2'd3, -1, -1, -1, 1'b0, txc, dc);
        check("after_reset_tx_len", txc, 192);
        check("after_reset_level", io_out[5:4], 3);

        repeat (12) begin
            repeat ($urandom_range(0, 6)) cycle();
            lv  = 2'($urandom_range(0, 3));
            len = (int'(lv) + 1) * 12 * P;
            a   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, len - 1)) : -1;
            et  = (a < 0 || a + 2 > len) ? len : a + 2;
            ed  = (a < 0 || a + 2 > len) ? 1 : 0;
            press(lv, a, -1, -1, 1'b0, txc, dc);
            check("rand_tx_len", txc, et);
            check("rand_done", dc, ed);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
